// File: rtl/ports_ctrl_pkg.sv
// Shared register map, field widths and helpers for the ports controller.
// Imported by the top level and by the key debouncer.
package ports_ctrl_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int LED_W    = 8;
    localparam int GPIO_W   = 8;
    localparam int PERIOD_W = 24;
    localparam int IDX_W    = 3;
    localparam int KEY_W    = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_LED    = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_GPIO   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_PAT    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_LEN    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_KEY    = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_EDGE   = 3'd7;

    localparam int CTRL_MODE_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int PAT_IDX_LSB     = 8;

    // Advance wraps to 0 at the last entry, or beyond it after SEQ_LEN shrinks.
    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] idx,
        input logic [IDX_W-1:0] len
    );
        return (idx >= len) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/ports_ctrl_key.sv
// Per-key 2-FF synchronizer and debouncer.
// state is 1 while the button is pressed; press pulses on acceptance of a press.
module key_debounce
    import ports_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic state,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive samples that disagree with the accepted state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], ~key_n};
            press <= 1'b0;
            if (sync[1] == state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                state <= sync[1];
                press <= sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ports_ctrl.sv
// Avalon-MM LED/GPIO/key port controller with an LED pattern sequencer.
// Two debounced keys feed a W1C press-capture register and a level irq.
module ports_ctrl
    import ports_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SEQ_DEPTH       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              irq,
    output logic [LED_W-1:0]  led,
    output logic [GPIO_W-1:0] gpio,
    input  logic [KEY_W-1:0]  key
);

    logic                mode;
    logic                irq_en;
    logic [LED_W-1:0]    led_direct;
    logic [GPIO_W-1:0]   gpio_out;
    logic [PERIOD_W-1:0] seq_period;
    logic [PERIOD_W-1:0] presc;
    logic [IDX_W-1:0]    seq_len;
    logic [IDX_W-1:0]    seq_idx;
    logic [LED_W-1:0]    pattern [SEQ_DEPTH];
    logic [KEY_W-1:0]    key_state;
    logic [KEY_W-1:0]    key_press;
    logic [KEY_W-1:0]    edge_q;

    logic wr_ctrl, wr_led, wr_gpio, wr_period;
    logic wr_pat, wr_len, wr_edge, mode_rise;
    logic [IDX_W-1:0]  pat_idx;
    logic [LED_W-1:0]  seq_led;
    logic [KEY_W-1:0]  edge_clr;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_led    = avs_write && (avs_address == ADDR_LED);
    assign wr_gpio   = avs_write && (avs_address == ADDR_GPIO);
    assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
    assign wr_pat    = avs_write && (avs_address == ADDR_PAT);
    assign wr_len    = avs_write && (avs_address == ADDR_LEN);
    assign wr_edge   = avs_write && (avs_address == ADDR_EDGE);

    assign mode_rise = wr_ctrl && avs_writedata[CTRL_MODE_BIT] && !mode;
    assign pat_idx   = avs_writedata[PAT_IDX_LSB +: IDX_W];
    assign edge_clr  = wr_edge ? avs_writedata[KEY_W-1:0] : '0;
    assign seq_led   = (int'(seq_idx) < SEQ_DEPTH) ? pattern[seq_idx] : '0;
    assign gpio      = gpio_out;

    assign unused_wdata = ^avs_writedata[DATA_W-1:PERIOD_W];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk   (clk),
        .reset (reset),
        .key_n (key[0]),
        .state (key_state[0]),
        .press (key_press[0])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk   (clk),
        .reset (reset),
        .key_n (key[1]),
        .state (key_state[1]),
        .press (key_press[1])
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode       <= 1'b0;
            irq_en     <= 1'b0;
            led_direct <= '0;
            gpio_out   <= '0;
            seq_period <= '0;
            seq_len    <= '0;
            for (int i = 0; i < SEQ_DEPTH; i++) begin
                pattern[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                mode   <= avs_writedata[CTRL_MODE_BIT];
                irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
            end
            if (wr_led) led_direct <= avs_writedata[LED_W-1:0];
            if (wr_gpio) gpio_out <= avs_writedata[GPIO_W-1:0];
            if (wr_period) seq_period <= avs_writedata[PERIOD_W-1:0];
            if (wr_len) seq_len <= avs_writedata[IDX_W-1:0];
            if (wr_pat && int'(pat_idx) < SEQ_DEPTH) begin
                pattern[pat_idx] <= avs_writedata[LED_W-1:0];
            end
        end
    end

    // A fresh start or a new period restarts the sequence from entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc   <= '0;
            seq_idx <= '0;
        end else if (mode_rise || wr_period) begin
            presc   <= '0;
            seq_idx <= '0;
        end else if (mode && seq_period != '0) begin
            if (presc >= seq_period) begin
                presc   <= '0;
                seq_idx <= next_idx(seq_idx, seq_len);
            end else begin
                presc <= presc + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (avs_address == ADDR_CTRL):   rd_mux[1:0] = {irq_en, mode};
            (avs_address == ADDR_LED):    rd_mux[LED_W-1:0] = led_direct;
            (avs_address == ADDR_GPIO):   rd_mux[GPIO_W-1:0] = gpio_out;
            (avs_address == ADDR_PERIOD): rd_mux[PERIOD_W-1:0] = seq_period;
            (avs_address == ADDR_LEN):    rd_mux[IDX_W-1:0] = seq_len;
            (avs_address == ADDR_KEY):    rd_mux[KEY_W-1:0] = key_state;
            (avs_address == ADDR_EDGE):   rd_mux[KEY_W-1:0] = edge_q;
            default:                      rd_mux = '0;
        endcase
    end

    // A press landing with a clear of the same bit keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            led          <= '0;
            edge_q       <= '0;
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            led    <= mode ? seq_led : led_direct;
            edge_q <= (edge_q & ~edge_clr) | key_press;
            irq    <= irq_en & (|edge_q);
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_ports_ctrl.sv
// Self-checking bench for ports_ctrl: random register traffic against a
// shadow model, then directed sequencer, debounce, W1C and reset scenarios.
module tb_ports_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  led;
    logic [7:0]  gpio;
    logic [1:0]  key;

    int checks = 0;
    int errors = 0;

    logic [1:0]  m_ctrl;
    logic [7:0]  m_led;
    logic [7:0]  m_gpio;
    logic [23:0] m_period;
    logic [2:0]  m_len;

    logic [7:0]  pats [3] = '{8'h01, 8'h02, 8'h04};
    logic [31:0] r;
    logic [2:0]  a;
    logic [31:0] d;
    logic        found;
    logic [7:0]  prev;

    always #5 clk = ~clk;

    ports_ctrl #(.DEBOUNCE_CYCLES(4), .SEQ_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .led           (led),
        .gpio          (gpio),
        .key           (key)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_rd(input logic [2:0] addr);
        case (addr)
            3'd0:    return {30'b0, m_ctrl};
            3'd1:    return {24'b0, m_led};
            3'd2:    return {24'b0, m_gpio};
            3'd3:    return {8'b0, m_period};
            3'd5:    return {29'b0, m_len};
            default: return 32'b0;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        key = 2'b11;
        m_ctrl = '0; m_led = '0; m_gpio = '0; m_period = '0; m_len = '0;
        idle(3);
        check("rst_led", led, 0);
        check("rst_gpio", gpio, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", avs_readdata, 0);
        reset = 1'b0;

        // Random register traffic, sequencer kept in direct mode.
        for (int i = 0; i < 60; i++) begin
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (a == 3'd0) d[0] = 1'b0;
                wr(a, d);
                case (a)
                    3'd0: m_ctrl = d[1:0];
                    3'd1: m_led = d[7:0];
                    3'd2: m_gpio = d[7:0];
                    3'd3: m_period = d[23:0];
                    3'd5: m_len = d[2:0];
                    default: ;
                endcase
            end else begin
                rd(a, r);
                check("rand_rd", r, model_rd(a));
                check("rand_led", led, m_led);
                check("rand_gpio", gpio, m_gpio);
                check("rand_irq", irq, 0);
            end
        end

        // Direct LED write and readback.
        wr(3'd0, 32'h0);
        wr(3'd1, 32'hA5);
        @(negedge clk);
        check("led_direct", led, 32'hA5);
        rd(3'd1, r);
        check("rd_led_direct", r, 32'hA5);

        // Sequencer: each entry shown for PERIOD+1 cycles.
        wr(3'd4, 32'h0000_0001);
        wr(3'd4, 32'h0000_0102);
        wr(3'd4, 32'h0000_0204);
        wr(3'd4, 32'h0000_0380);
        wr(3'd5, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("seq_step", led, pats[(i / 4) % 3]);
        end

        // Shrink SEQ_LEN while showing entry 2.
        found = 1'b0;
        prev  = led;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (led == 8'h04 && prev != 8'h04) found = 1'b1;
            prev = led;
        end
        check("seq_reach_idx2", found, 1);
        wr(3'd5, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (led == 8'h01) found = 1'b1;
        end
        check("seq_len_wrap", found, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("seq_len_hold", led, 32'h01);
        end

        // Debounce: short bouncy presses are rejected.
        wr(3'd0, 32'd2);
        wr(3'd7, 32'd3);
        key[0] = 1'b0; idle(3);
        key[0] = 1'b1; idle(2);
        key[0] = 1'b0; idle(1);
        key[0] = 1'b1; idle(1);
        key[0] = 1'b0; idle(3);
        key[0] = 1'b1; idle(8);
        rd(3'd6, r);
        check("bounce_key", r, 0);
        rd(3'd7, r);
        check("bounce_edge", r, 0);
        check("bounce_irq", irq, 0);

        key[0] = 1'b0; idle(10);
        idle(2);
        rd(3'd6, r);
        check("press_key", r, 1);
        rd(3'd7, r);
        check("press_edge", r, 1);
        check("press_irq", irq, 1);

        wr(3'd7, 32'd1);
        rd(3'd7, r);
        check("w1c_edge", r, 0);
        check("w1c_irq", irq, 0);

        key[0] = 1'b1; idle(12);
        rd(3'd6, r);
        check("release_key", r, 0);
        key[0] = 1'b0; idle(12);
        rd(3'd7, r);
        check("repress_edge", r, 1);
        check("repress_irq", irq, 1);

        // Clear arriving in the same cycle as a new press.
        key[0] = 1'b1; idle(12);
        key[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (dut.u_key0.press) found = 1'b1;
        end
        check("coinc_press_seen", found, 1);
        avs_address   = 3'd7;
        avs_writedata = 32'd1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("coinc_irq", irq, 1);
            @(negedge clk);
        end
        rd(3'd7, r);
        check("coinc_edge", r, 1);

        // Reset in the middle of a running sequence.
        key[0] = 1'b1; idle(12);
        wr(3'd2, 32'h5A);
        wr(3'd5, 32'd2);
        wr(3'd0, 32'd3);
        idle(6);
        rd(3'd1, r);
        check("pre_rst_gpio", gpio, 32'h5A);
        check("pre_rst_irq", irq, 1);
        @(negedge clk);
        reset         = 1'b1;
        avs_address   = 3'd2;
        avs_writedata = 32'hFF;
        avs_write     = 1'b1;
        @(negedge clk);
        check("mid_rst_led", led, 0);
        check("mid_rst_gpio", gpio, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_rdata", avs_readdata, 0);
        @(negedge clk);
        avs_write = 1'b0;
        reset     = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd(3'(i), r);
            check("post_rst_rd", r, 0);
        end
        check("post_rst_gpio", gpio, 0);
        check("post_rst_led", led, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
